// File: rtl/maze_path_recorder.sv
// maze_path_recorder: logs the committed moves of a maze solver into a step
// buffer, marks visited cells in a GRID x GRID bitmap, flags illegal moves,
// revisits and buffer overflow, freezes the path at the goal and keeps the
// shortest completed path length across restarts.
//
// Handshake: there is no valid/ready pair. Every clock edge samples the solver
// outputs; a move is any cycle whose position differs from the last logged
// step. restart is a single-cycle pulse that takes priority over moves and found.
module maze_path_recorder #(
   parameter int MAX_STEPS = 50,
   parameter int GRID      = 10,
   parameter int GOAL_X    = 9,
   parameter int GOAL_Y    = 9,
   parameter int LEN_W     = $clog2(MAX_STEPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       x_pos,
   input  logic [3:0]       y_pos,
   input  logic [2:0]       direction,
   input  logic             found,
   input  logic             restart,
   input  logic [LEN_W-1:0] rd_addr,
   output logic [7:0]       rd_data,
   output logic [LEN_W-1:0] path_len,
   output logic             path_done,
   output logic [LEN_W-1:0] best_len,
   output logic             new_best,
   output logic             illegal_move,
   output logic             loop_seen,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_RECORD, S_DONE, S_OVF} state_t;

   localparam int               CELLS    = GRID * GRID;
   localparam int               CELL_W   = $clog2(CELLS);
   localparam logic [3:0]       GRID_C   = 4'(GRID);
   localparam logic [3:0]       GOAL_X_C = 4'(GOAL_X);
   localparam logic [3:0]       GOAL_Y_C = 4'(GOAL_Y);
   localparam logic [LEN_W-1:0] MAX_C    = LEN_W'(MAX_STEPS);

   state_t             state_q, state_d;
   logic [7:0]         buf_q [MAX_STEPS];
   logic [7:0]         buf_d [MAX_STEPS];
   logic [CELLS-1:0]   visited_q, visited_d;
   logic [LEN_W-1:0]   path_len_q, path_len_d;
   logic [LEN_W-1:0]   best_len_q, best_len_d;
   logic               new_best_q, new_best_d;
   logic               illegal_q, illegal_d;
   logic               loop_q, loop_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         rd_data_q, rd_data_d;

   logic [7:0]         cur_pos, last_pos;
   logic [3:0]         last_x, last_y, dx, dy;
   logic [4:0]         manhattan;
   logic [LEN_W-1:0]   last_idx;
   logic [CELL_W-1:0]  cell_idx;
   logic               in_range, moved, at_goal, adjacent, dir_match, full, ovf_now;

   assign cur_pos   = {x_pos, y_pos};
   assign last_idx  = path_len_q - LEN_W'(1);
   assign last_pos  = buf_q[last_idx];
   assign last_x    = last_pos[7:4];
   assign last_y    = last_pos[3:0];
   assign in_range  = (x_pos < GRID_C) && (y_pos < GRID_C);
   assign at_goal   = (x_pos == GOAL_X_C) && (y_pos == GOAL_Y_C);
   assign moved     = (cur_pos != last_pos);
   assign full      = (path_len_q == MAX_C);
   assign ovf_now   = moved && in_range && full;
   assign cell_idx  = CELL_W'(y_pos) * CELL_W'(GRID) + CELL_W'(x_pos);
   assign dx        = (x_pos >= last_x) ? (x_pos - last_x) : (last_x - x_pos);
   assign dy        = (y_pos >= last_y) ? (y_pos - last_y) : (last_y - y_pos);
   assign manhattan = {1'b0, dx} + {1'b0, dy};
   assign adjacent  = (manhattan == 5'd1);

   // Does the position change agree with the announced move code?
   always_comb begin
      dir_match = 1'b0;
      case (direction)
         3'b000:  dir_match = (x_pos == last_x) && (y_pos + 4'd1 == last_y);
         3'b001:  dir_match = (x_pos == last_x) && (y_pos == last_y + 4'd1);
         3'b010:  dir_match = (y_pos == last_y) && (x_pos + 4'd1 == last_x);
         3'b011:  dir_match = (y_pos == last_y) && (x_pos == last_x + 4'd1);
         default: dir_match = 1'b0;
      endcase
   end

   // Next-state, logging and flag logic; restart overrides everything else.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      visited_d  = visited_q;
      path_len_d = path_len_q;
      best_len_d = best_len_q;
      new_best_d = 1'b0;
      illegal_d  = illegal_q;
      loop_d     = loop_q;
      overflow_d = overflow_q;
      if (restart) begin
         state_d    = S_IDLE;
         buf_d      = '{default: '0};
         visited_d  = '0;
         path_len_d = '0;
         illegal_d  = 1'b0;
         loop_d     = 1'b0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_range) begin
                  buf_d[0]            = cur_pos;
                  visited_d[cell_idx] = 1'b1;
                  path_len_d          = LEN_W'(1);
                  state_d             = S_RECORD;
               end else begin
                  illegal_d = 1'b1;
               end
            end
            S_RECORD: begin
               if (moved) begin
                  if (!in_range) begin
                     illegal_d = 1'b1;
                  end else if (full) begin
                     overflow_d = 1'b1;
                     state_d    = S_OVF;
                  end else begin
                     buf_d[path_len_q]   = cur_pos;
                     visited_d[cell_idx] = 1'b1;
                     path_len_d          = path_len_q + LEN_W'(1);
                     if (!adjacent || !dir_match) illegal_d = 1'b1;
                     if (visited_q[cell_idx]) loop_d = 1'b1;
                  end
               end
               if (found) begin
                  if (!at_goal) begin
                     illegal_d = 1'b1;
                  end else if (!ovf_now) begin
                     // Any move in this cycle is already logged, so the
                     // goal cell counts toward the completed length.
                     state_d = S_DONE;
                     if (path_len_d < best_len_q) begin
                        best_len_d = path_len_d;
                        new_best_d = 1'b1;
                     end
                  end
               end
            end
            default: begin
               // DONE and OVF hold everything until restart or rst.
            end
         endcase
      end
   end

   // Registered read port; reads see the buffer before this cycle's write.
   always_comb begin
      rd_data_d = 8'h00;
      if (rd_addr < path_len_q) rd_data_d = buf_q[rd_addr];
   end

   // State and storage registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         buf_q      <= '{default: '0};
         visited_q  <= '0;
         path_len_q <= '0;
         best_len_q <= '1;
         new_best_q <= 1'b0;
         illegal_q  <= 1'b0;
         loop_q     <= 1'b0;
         overflow_q <= 1'b0;
         rd_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         visited_q  <= visited_d;
         path_len_q <= path_len_d;
         best_len_q <= best_len_d;
         new_best_q <= new_best_d;
         illegal_q  <= illegal_d;
         loop_q     <= loop_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_data      = rd_data_q;
   assign path_len     = path_len_q;
   assign path_done    = (state_q == S_DONE);
   assign best_len     = best_len_q;
   assign new_best     = new_best_q;
   assign illegal_move = illegal_q;
   assign loop_seen    = loop_q;
   assign overflow     = overflow_q;
   assign dbg_state    = state_q;

endmodule

// File: doc/maze_path_recorder.md
Name: maze_path_recorder

Overview:
- Downstream consumer of the maze solver outputs (x_pos, y_pos, direction, found).
- Logs every committed move of the solver into a step buffer and marks visited cells in a 10x10 bitmap.
- Flags illegal moves and revisits; on arrival at the goal, freezes the path and reports its length.
- Tracks the shortest completed path across restarts and exposes the logged path through a registered read port.

Parameters:
- MAX_STEPS, 50, step buffer depth (entries 0..MAX_STEPS-1)
- GRID, 10, maze edge length; legal coordinates are 0..GRID-1
- GOAL_X, 9, goal column
- GOAL_Y, 9, goal row
- LEN_W, 6, width of length counters, equal to $clog2(MAX_STEPS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- x_pos  in  4  solver current column
- y_pos  in  4  solver current row
- direction  in  3  solver move code: 000 y-1, 001 y+1, 010 x-1, 011 x+1, 110 hold; other codes are treated as hold
- found  in  1  solver goal indication
- restart  in  1  single-cycle pulse; clears the current path and keeps best_len
- rd_addr  in  LEN_W  step index to read
- rd_data  out  8  {x[3:0], y[3:0]} of step rd_addr; 1-cycle latency
- path_len  out  LEN_W  number of steps currently logged
- path_done  out  1  high while the path is frozen at the goal
- best_len  out  LEN_W  shortest completed path length; all-ones = none yet
- new_best  out  1  one-cycle pulse when best_len improves
- illegal_move  out  1  sticky: non-adjacent jump or out-of-range coordinate
- loop_seen  out  1  sticky: solver entered an already-visited cell
- overflow  out  1  sticky: a move was attempted with the buffer full

Behaviour:
- Reset (async): state IDLE. path_len=0, best_len=all-ones, rd_data=0. All flags, path_done and new_best = 0. Bitmap and buffer cleared.
- States: IDLE, RECORD, DONE, OVF.
- IDLE: on the first cycle out of reset or restart, captures (x_pos,y_pos) as step 0, sets its bitmap bit, sets path_len=1, and goes to RECORD. An out-of-range start sets illegal_move and stays in IDLE.
- RECORD, move detection: a move is a cycle where (x_pos,y_pos) differs from the last logged step.
- RECORD, move checks: coordinate >= GRID -> illegal_move, nothing logged. Manhattan distance != 1 -> illegal_move, but the step is still logged. Bitmap bit already set -> loop_seen, step logged.
- RECORD, normal logging: buffer[path_len] <= position; bitmap bit set; path_len++.
- RECORD, full buffer: a move while path_len==MAX_STEPS -> overflow=1 and go to OVF; nothing is written.
- RECORD, goal: found && position==(GOAL_X,GOAL_Y) -> go to DONE. If a move occurs in the same cycle, it is logged first, so path_len includes the goal cell.
- RECORD, spurious found: found when the position is not the goal -> illegal_move; found is otherwise ignored.
- direction is used only for consistency: a move whose delta does not match direction sets illegal_move. A hold code with no position change is not an error.
- DONE: path_done=1; buffer and path_len frozen. On entry, if path_len < best_len, best_len <= path_len and new_best pulses for one cycle. A tie does not update best_len.
- OVF: frozen; path_done=0; exits only via restart or rst.
- restart (any state): next cycle IDLE; buffer, bitmap, path_len, path_done and the sticky flags are cleared; best_len is kept.
- Simultaneous events: restart wins over found and over moves. rst wins over everything.
- Read port: rd_data <= (rd_addr < path_len) ? buffer[rd_addr] : 8'h00, registered. Reads are allowed in any state. A read of the index being written in the same cycle returns the old contents (read-before-write).
- All arithmetic is unsigned. path_len never exceeds MAX_STEPS; there is no wrap-around.

Test Plan:
- Path (0,0)->(1,0)->(1,1)->...->(9,9), 19 cells, found at (9,9) -> path_done=1, path_len=19, best_len=19, new_best one pulse, no flags; rd_addr=18 gives 8'h99 the next cycle.
- restart, then a 23-cell path to the goal -> best_len stays 19, no new_best. Restart, then a 19-cell path -> no new_best (tie).
- Jump from (2,2) to (4,2) -> illegal_move=1, step logged, path_len increments. Move to x=12 -> illegal_move, path_len unchanged.
- Sequence (3,3)->(3,4)->(3,3) -> loop_seen=1 on the third step; the path continues recording.
- 50 distinct logged cells, then one more move -> overflow=1, state OVF, path_len=50; further moves are ignored. restart -> all flags clear and path_len=1.
- rst asserted mid-RECORD at path_len=7 -> all outputs go to reset values immediately, including best_len=all-ones. restart and found in the same cycle -> IDLE, path_done stays 0.
